// File: rtl/mont_prod_pkg.sv
// Shared constants and FSM encoding for the Montgomery product engine.
package mont_prod_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOOP,
    ST_REDUCE,
    ST_WRITE
  } state_t;
endpackage

// File: rtl/mont_prod_word_add.sv
// One word column of the radix-2 Montgomery step: S_j + a_i*B_j + q*M_j + carry.
module mont_prod_word_add
  import mont_prod_pkg::*;
(
  input  logic [WORD_W-1:0] s,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] m,
  input  logic              a_bit,
  input  logic              q,
  input  logic [1:0]        cin,
  output logic [WORD_W-1:0] sum,
  output logic [1:0]        cout
);
  logic [WORD_W+1:0] total;

  always_comb begin
    total = {2'b00, s}
          + (a_bit ? {2'b00, b} : '0)
          + (q     ? {2'b00, m} : '0)
          + {{WORD_W{1'b0}}, cin};
  end

  assign sum  = total[WORD_W-1:0];
  assign cout = total[WORD_W+1:WORD_W];
endmodule

// File: rtl/mont_prod.sv
// Word-serial radix-2 Montgomery product: result = A*B*2^(-32*length) mod M.
module mont_prod
  import mont_prod_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] length,
  input  logic              calculate,
  output logic              ready,
  output logic [ADDR_W-1:0] opa_addr,
  input  logic [WORD_W-1:0] opa_data,
  output logic [ADDR_W-1:0] opb_addr,
  input  logic [WORD_W-1:0] opb_data,
  output logic [ADDR_W-1:0] opm_addr,
  input  logic [WORD_W-1:0] opm_data,
  output logic [ADDR_W-1:0] result_addr,
  output logic [WORD_W-1:0] result_data,
  output logic              result_we
);
  state_t state, next_state;

  logic [WORD_W-1:0] s_mem [256];
  logic [1:0]        top_r, carry_r;
  logic [WORD_W-1:0] prev_r;
  logic [ADDR_W-1:0] len_r, wc, rd_addr, opa_addr_r;
  logic [12:0]       bit_cnt;
  logic              pre, pass, q_r, bor_r;

  logic [ADDR_W-1:0] len_m1, sa;
  logic [12:0]       bit_nxt;
  logic [WORD_W-1:0] s_word, sum;
  logic [1:0]        cout, add_cin;
  logic [2:0]        ext;
  logic [WORD_W:0]   diff;
  logic              first_word, last_word, last_bit, a_bit, q_now, q_eff, ge_now;

  assign len_m1     = len_r - 8'd1;
  assign sa         = len_m1 - wc;
  assign s_word     = s_mem[sa];
  assign bit_nxt    = bit_cnt + 13'd1;
  assign first_word = (wc == '0);
  assign last_word  = !pre && (wc == len_m1);
  assign last_bit   = (bit_cnt == {len_m1, 5'h1f});
  assign a_bit      = opa_data[bit_cnt[4:0]];
  // q is decided on the least significant word and then held for the whole sweep
  assign q_now      = s_word[0] ^ (a_bit & opb_data[0]);
  assign q_eff      = first_word ? q_now : q_r;
  assign add_cin    = first_word ? 2'b00 : carry_r;
  assign ext        = {1'b0, top_r} + {1'b0, cout};
  assign diff       = {1'b0, s_word} - {1'b0, opm_data} - {{WORD_W{1'b0}}, (!first_word && bor_r)};
  assign ge_now     = (top_r != 2'b00) || !diff[WORD_W];

  mont_prod_word_add u_add (
    .s     (s_word),
    .b     (opb_data),
    .m     (opm_data),
    .a_bit (a_bit),
    .q     (q_eff),
    .cin   (add_cin),
    .sum   (sum),
    .cout  (cout)
  );

  assign opa_addr = opa_addr_r;
  assign opb_addr = rd_addr;
  assign opm_addr = rd_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (calculate) next_state = ST_INIT;
      ST_INIT:   next_state = (len_r == '0) ? ST_IDLE : ST_LOOP;
      ST_LOOP:   if (last_word && last_bit) next_state = ST_REDUCE;
      ST_REDUCE: if (last_word && (pass || !ge_now)) next_state = ST_WRITE;
      ST_WRITE:  if (wc == len_r) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) s_mem[i[ADDR_W-1:0]] <= '0;
      top_r <= '0; carry_r <= '0; prev_r <= '0;
      len_r <= '0; wc <= '0; rd_addr <= '0; opa_addr_r <= '0; bit_cnt <= '0;
      pre <= 1'b0; pass <= 1'b0; q_r <= 1'b0; bor_r <= 1'b0;
      ready <= 1'b1; result_we <= 1'b0; result_addr <= '0; result_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          result_we <= 1'b0;
          if (calculate) begin
            len_r <= length;
            ready <= 1'b0;
          end
        end
        ST_INIT: begin
          for (int i = 0; i < 256; i++) s_mem[i[ADDR_W-1:0]] <= '0;
          top_r <= '0; bit_cnt <= '0; wc <= '0; pre <= 1'b1;
          rd_addr <= len_m1; opa_addr_r <= len_m1;
          if (len_r == '0) ready <= 1'b1;
        end
        ST_LOOP: begin
          rd_addr <= rd_addr - 8'd1;
          if (pre) begin
            pre <= 1'b0;
          end else begin
            // shifted-right store: this column's LSB completes the word below it
            if (!first_word) s_mem[sa + 8'd1] <= {sum[0], prev_r[WORD_W-1:1]};
            if (first_word) q_r <= q_now;
            prev_r  <= sum;
            carry_r <= cout;
            wc      <= wc + 8'd1;
            if (wc == len_m1) begin
              s_mem[sa]  <= {ext[0], sum[WORD_W-1:1]};
              top_r      <= ext[2:1];
              wc         <= '0;
              pre        <= 1'b1;
              rd_addr    <= len_m1;
              bit_cnt    <= bit_nxt;
              opa_addr_r <= len_m1 - bit_nxt[12:5];
              pass       <= 1'b0;
            end
          end
        end
        ST_REDUCE: begin
          rd_addr <= rd_addr - 8'd1;
          if (pre) begin
            pre <= 1'b0;
          end else begin
            // pass 0 only compares; pass 1 writes S - M back in place
            if (pass) s_mem[sa] <= diff[WORD_W-1:0];
            bor_r <= diff[WORD_W];
            wc    <= wc + 8'd1;
            if (wc == len_m1) begin
              wc      <= '0;
              pre     <= 1'b1;
              rd_addr <= len_m1;
              if (pass)        top_r <= '0;
              else if (ge_now) pass  <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          if (wc == len_r) begin
            result_we <= 1'b0;
            ready     <= 1'b1;
          end else begin
            result_we   <= 1'b1;
            result_addr <= wc;
            result_data <= s_mem[wc];
            wc          <= wc + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mont_prod.sv
// Directed bench for mont_prod with a bignum reference model and a write monitor.
module tb_mont_prod;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  length = '0;
  logic        calculate = 1'b0;
  logic        ready;
  logic [7:0]  opa_addr, opb_addr, opm_addr, result_addr;
  logic [31:0] opa_data, opb_data, opm_data, result_data;
  logic        result_we;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_m [256];
  logic [31:0] mem_r [256];
  logic [31:0] exp_w [256];
  int          exp_len = 0;
  int          wr_cnt = 0;
  bit          writes_allowed = 1'b0;
  int          checks = 0;
  int          failures = 0;

  mont_prod dut (
    .clk(clk), .reset_n(reset_n), .length(length), .calculate(calculate), .ready(ready),
    .opa_addr(opa_addr), .opa_data(opa_data), .opb_addr(opb_addr), .opb_data(opb_data),
    .opm_addr(opm_addr), .opm_data(opm_data), .result_addr(result_addr),
    .result_data(result_data), .result_we(result_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    opa_data <= mem_a[opa_addr];
    opb_data <= mem_b[opb_addr];
    opm_data <= mem_m[opm_addr];
    if (result_we) mem_r[result_addr] <= result_data;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // A*B mod M, then 32*len modular halvings give the factor 2^(-32*len).
  function automatic logic [511:0] mont_model(input logic [511:0] a, b, m, input int len);
    logic [511:0] x;
    x = (a * b) % m;
    for (int i = 0; i < 32 * len; i++) x = x[0] ? (x + m) >> 1 : x >> 1;
    return x;
  endfunction

  // Every result write is checked against the model word at the same index.
  always @(negedge clk) begin
    if (result_we) begin
      if (!writes_allowed || wr_cnt >= exp_len) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h count=%0d", result_addr, result_data, wr_cnt);
      end else begin
        check("wr_addr", {56'd0, result_addr}, wr_cnt);
        check("wr_data", {32'd0, result_data}, {32'd0, exp_w[wr_cnt]});
      end
      wr_cnt++;
    end
  end

  task automatic start_op(input int len, input logic [511:0] a, b, m, input string tag);
    logic [511:0] r;
    r = mont_model(a, b, m, len);
    for (int k = 0; k < len; k++) begin
      mem_a[k] = a[32*(len-1-k) +: 32];
      mem_b[k] = b[32*(len-1-k) +: 32];
      mem_m[k] = m[32*(len-1-k) +: 32];
      exp_w[k] = r[32*(len-1-k) +: 32];
      mem_r[k] = 32'hDEAD_BEEF;
    end
    exp_len = len;
    wr_cnt  = 0;
    length  = len[7:0];
    @(posedge clk); #1 calculate = 1'b1;
    @(posedge clk); #1 calculate = 1'b0;
    check({tag, "_ready_drop"}, {63'd0, ready}, 64'd0);
  endtask

  task automatic run_op(input int len, input logic [511:0] a, b, m, input int mid_pulse,
                        input string tag);
    int cyc, bound;
    writes_allowed = 1'b1;
    start_op(len, a, b, m, tag);
    bound = 32 * len * (2 * len + 4) + 4 * len + 8;
    cyc = 1;
    while (ready !== 1'b1 && cyc < bound + 2) begin
      if (cyc == mid_pulse) calculate = 1'b1;
      @(posedge clk); #1;
      calculate = 1'b0;
      cyc++;
    end
    check({tag, "_latency_ok"}, {63'd0, (ready === 1'b1 && cyc <= bound)}, 64'd1);
    check({tag, "_write_count"}, wr_cnt, len);
    for (int k = 0; k < len; k++) check({tag, "_mem_r"}, {32'd0, mem_r[k]}, {32'd0, exp_w[k]});
    repeat (3) @(posedge clk);
    #1 check({tag, "_idle_ready"}, {63'd0, ready}, 64'd1);
    writes_allowed = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0; mem_b[i] = '0; mem_m[i] = '0; mem_r[i] = '0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_we", {63'd0, result_we}, 64'd0);
    check("rst_data", {32'd0, result_data}, 64'd0);
    check("rst_raddr", {56'd0, result_addr}, 64'd0);
    check("rst_opa", {56'd0, opa_addr}, 64'd0);
    check("rst_opb", {56'd0, opb_addr}, 64'd0);
    check("rst_opm", {56'd0, opm_addr}, 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // hand-computed values pin the reference model
    check("model_v1", mont_model(512'h9, 512'h7, 512'h13, 1)[63:0], 64'h1);
    check("model_v2", mont_model(512'hb, 512'h2, 512'h11, 1)[63:0], 64'h5);
    check("model_v3", mont_model(512'h2, 512'ha, 512'hb, 1)[63:0], 64'h5);
    check("model_v4", mont_model(512'h11, 512'h8000, 512'h10001, 1)[63:0], 64'h7ff8);
    check("model_v5", mont_model(512'h20002, 512'h22, 512'h7fffffff, 1)[63:0], 64'h220022);
    check("model_v7", mont_model(512'h1, 512'h1, 512'h00000001_00000001, 2)[63:0], 64'h1);

    run_op(1, 512'h9, 512'h7, 512'h13, 0, "v1");
    run_op(1, 512'hb, 512'h2, 512'h11, 0, "v2");
    run_op(1, 512'h2, 512'ha, 512'hb, 0, "v3");
    run_op(1, 512'h11, 512'h8000, 512'h10001, 0, "v4");
    run_op(1, 512'h20002, 512'h22, 512'h7fffffff, 0, "v5");
    run_op(1, 512'hFFFFFFFA, 512'hFFFFFFF0, 512'hFFFFFFFB, 0, "v6");
    run_op(2, 512'h1, 512'h1, 512'h00000001_00000001, 0, "v7");
    run_op(2, 512'h7FFFFFFF_FFFFFFFF, 512'h80000000_00000000, 512'h80000000_00000001, 0, "v10");
    run_op(3, 512'h01234567_89ABCDEF_FEDCBA98, 512'hE0000000_12345678_9ABCDEF1,
           512'hF1234567_89ABCDEF_01234567, 0, "v8");
    run_op(4, 512'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 512'hC0000000_00000000_00000000_00000003,
           512'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC5, 0, "v9");

    // calculate pulsed while busy must not disturb the result
    run_op(3, 512'h01234567_89ABCDEF_FEDCBA98, 512'hE0000000_12345678_9ABCDEF1,
           512'hF1234567_89ABCDEF_01234567, 50, "midcalc");

    // length 0: quick return, no writes
    writes_allowed = 1'b0;
    start_op(0, 512'h0, 512'h0, 512'h1, "len0");
    cyc = 1;
    while (ready !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("len0_ready_time", {63'd0, (ready === 1'b1 && cyc <= 4)}, 64'd1);
    repeat (4) @(posedge clk);
    #1 check("len0_no_writes", wr_cnt, 0);

    // reset during LOOP aborts without writes
    writes_allowed = 1'b0;
    start_op(4, 512'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 512'h3,
             512'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFC5, "rstmid");
    repeat (40) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_ready", {63'd0, ready}, 64'd1);
    check("rstmid_we", {63'd0, result_we}, 64'd0);
    check("rstmid_opa", {56'd0, opa_addr}, 64'd0);
    check("rstmid_opb", {56'd0, opb_addr}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("rstmid_no_writes", wr_cnt, 0);
    check("rstmid_idle", {63'd0, ready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
